hv_stream_out: RTL

- Downstream neighbour of the per-bit majority/counter buffer stage.
- Accepts finished 1024-bit sign-bit hypervectors, one per in_valid pulse, into a two-entry ping-pong buffer.
- Serializes each hypervector onto a 64-bit AXI4-Stream master toward the ACP DMA.
- Asserts tlast on the final beat of the final hypervector of a job, then pulses done.

---
 rtl/hpu_stream_pkg.sv | 13 +
 rtl/hv_pingpong_buf.sv | 54 +++++
 rtl/hv_stream_out.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hpu_stream_pkg.sv
// Shared types and helpers for the hypervector output stream path.
package hpu_stream_pkg;

  localparam int unsigned OUT_W_DEFAULT = 64;

  typedef enum logic [1:0] {IDLE, RUN, FIN} hv_out_state_t;

  // Number of OUT_W-bit beats needed to carry one (dim+1)-bit hypervector.
  function automatic int unsigned beats(input int unsigned dim, input int unsigned out_w);
    return (dim + 1) / out_w;
  endfunction

endpackage

// File: rtl/hv_pingpong_buf.sv
// Two-entry hypervector FIFO; exposes both the head and the entry behind it so
// the serializer can cross a vector boundary without a bubble.
module hv_pingpong_buf
  import hpu_stream_pkg::*;
#(
  parameter int unsigned W = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_free,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rd_data,
  output logic [W-1:0] rd_next_data
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_en, rd_free})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (wr_en)   wr_ptr_q <= ~wr_ptr_q;
      if (rd_free) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full         = (cnt_q == 2'd2);
  assign empty        = (cnt_q == 2'd0);
  assign rd_data      = mem_q[rd_ptr_q];
  assign rd_next_data = mem_q[~rd_ptr_q];

endmodule

// File: rtl/hv_stream_out.sv
// Buffers finished hypervectors in a ping-pong pair and serializes them onto a
// 64-bit AXI4-Stream master, marking the last beat of the job with tlast.
module hv_stream_out
  import hpu_stream_pkg::*;
#(
  parameter int unsigned DIM   = 1023,
  parameter int unsigned OUT_W = OUT_W_DEFAULT,
  parameter int unsigned CNT_W = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  input  logic [DIM:0]     in_data,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             out_tlast,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned Beats = beats(DIM, OUT_W);
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  hv_out_state_t    state_q, state_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] emit_cnt_q, emit_cnt_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic [OUT_W-1:0] tdata_q, tdata_d;
  logic             overflow_q, overflow_d;

  logic             buf_full, buf_empty;
  logic [DIM:0]     buf_rd_data, buf_rd_next_data;

  logic             start_acc, hs, release_slot, accept, load;
  logic [DIM:0]     src;
  int unsigned      src_off;

  assign start_acc    = start && (state_q == IDLE);
  assign hs           = tvalid_q && out_tready;
  assign release_slot = hs && (beat_q == LastBeat);
  // A slot freed by this cycle's final beat may be refilled in the same cycle.
  assign in_ready     = (state_q == RUN) && (!buf_full || release_slot) &&
                        (acc_cnt_q < num_vec_q);
  assign accept       = in_valid && in_ready;

  hv_pingpong_buf #(
    .W (DIM + 1)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (accept),
    .wr_data      (in_data),
    .rd_free      (release_slot),
    .full         (buf_full),
    .empty        (buf_empty),
    .rd_data      (buf_rd_data),
    .rd_next_data (buf_rd_next_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (num_vec == '0) ? FIN : RUN;
      RUN:     if (hs && tlast_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == FIN);
  end

  always_comb begin
    num_vec_d  = num_vec_q;
    acc_cnt_d  = acc_cnt_q;
    emit_cnt_d = emit_cnt_q;
    overflow_d = overflow_q;
    if (start_acc) begin
      num_vec_d  = num_vec;
      acc_cnt_d  = '0;
      emit_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept)       acc_cnt_d  = acc_cnt_q + CNT_W'(1);
      if (release_slot) emit_cnt_d = emit_cnt_q + CNT_W'(1);
    end
    if (in_valid && !in_ready) overflow_d = 1'b1;
  end

  // Serializer: pick the vector feeding the next beat, looking through the buffer
  // to the incoming data so a fresh vector shows up one cycle after acceptance.
  always_comb begin
    tvalid_d = tvalid_q;
    beat_d   = beat_q;
    src      = buf_rd_data;
    load     = 1'b0;
    if (!tvalid_q || hs) begin
      if (tvalid_q && !release_slot) begin
        beat_d = beat_q + BeatW'(1);
        load   = 1'b1;
      end else begin
        beat_d = '0;
        if (release_slot && buf_full) begin
          src  = buf_rd_next_data;
          load = 1'b1;
        end else if (!release_slot && !buf_empty) begin
          load = 1'b1;
        end else if (accept) begin
          src  = in_data;
          load = 1'b1;
        end
      end
      tvalid_d = load;
    end
    src_off = 32'(beat_d) * OUT_W;
    tdata_d = load ? src[src_off +: OUT_W] : tdata_q;
    tlast_d = load ? ((beat_d == LastBeat) && (emit_cnt_d == num_vec_q - CNT_W'(1))) : tlast_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_vec_q  <= '0;
      acc_cnt_q  <= '0;
      emit_cnt_q <= '0;
      beat_q     <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      num_vec_q  <= num_vec_d;
      acc_cnt_q  <= acc_cnt_d;
      emit_cnt_q <= emit_cnt_d;
      beat_q     <= beat_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_tdata  = tdata_q;
  assign out_tvalid = tvalid_q;
  assign out_tlast  = tlast_q;
  assign overflow   = overflow_q;

endmodule
